keypad_scan_debounce: RTL

//  Scans the 4x3 matrix keypad one column at a time and debounces the row returns.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_scan_debounce_if.sv | 19 +
 rtl/keypad_sync2.sv | 19 +
 rtl/keypad_scan_debounce.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x3 keypad scanner and debouncer.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_SHARP = 4'hB;

  // Rows 1-3 carry the digits 1-9 in reading order; row 4 is '*', '0', '#'.
  function automatic logic [3:0] rc_to_code(input logic [3:0] row, input logic [2:0] col);
    logic [3:0] r;
    logic [3:0] c;
    logic [3:0] code;
    r = row[1] ? 4'd1 : row[2] ? 4'd2 : 4'd0;
    c = col[1] ? 4'd1 : col[2] ? 4'd2 : 4'd0;
    if (row[3])
      code = col[0] ? KEY_STAR : col[1] ? 4'h0 : KEY_SHARP;
    else
      code = r * 4'd3 + c + 4'd1;
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Keypad pin and key-report signals; slave is the scanner, master the surrounding system.
interface keypad_scan_debounce_if;
  logic [3:0] row_in;
  logic [2:0] col_drive;
  logic [3:0] row_out;
  logic [2:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;

  modport master (
    output row_in,
    input  col_drive, row_out, col_out, key_valid, key_code
  );

  modport slave (
    input  row_in,
    output col_drive, row_out, col_out, key_valid, key_code
  );
endinterface

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser for the asynchronous keypad row returns.
module keypad_sync2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scan_debounce.sv
// Column scanner, press/release debouncer and single-key reporter for a 4x3 keypad.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every REPEAT_CYCLES while a key is held.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input logic clk,
  input logic rst_n,
  keypad_scan_debounce_if.slave kp
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("keypad_scan_debounce: SCAN_DIV must be >= 4 and the cycle counts positive");
  end

  state_t        state, state_d;
  logic [3:0]    rs;
  logic [2:0]    col_drive_q, col_drive_d, col_rot;
  logic [3:0]    cand_row, cand_row_d;
  logic [2:0]    cand_col, cand_col_d;
  logic [DW-1:0] dwell_cnt, dwell_d;
  logic [BW-1:0] deb_cnt, deb_d;
  logic [BW-1:0] rel_cnt, rel_d;
  logic [3:0]    row_out_q, row_out_d;
  logic [2:0]    col_out_q, col_out_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt, rep_d;
`endif

  keypad_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (kp.row_in),
    .q     (rs)
  );

  assign col_rot = {col_drive_q[1:0], col_drive_q[2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCAN;
      col_drive_q <= 3'b001;
      cand_row    <= '0;
      cand_col    <= '0;
      dwell_cnt   <= '0;
      deb_cnt     <= '0;
      rel_cnt     <= '0;
      row_out_q   <= '0;
      col_out_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      state       <= state_d;
      col_drive_q <= col_drive_d;
      cand_row    <= cand_row_d;
      cand_col    <= cand_col_d;
      dwell_cnt   <= dwell_d;
      deb_cnt     <= deb_d;
      rel_cnt     <= rel_d;
      row_out_q   <= row_out_d;
      col_out_q   <= col_out_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt     <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d     = state;
    col_drive_d = col_drive_q;
    cand_row_d  = cand_row;
    cand_col_d  = cand_col;
    dwell_d     = dwell_cnt;
    deb_d       = deb_cnt;
    rel_d       = rel_cnt;
    row_out_d   = row_out_q;
    col_out_d   = col_out_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d       = rep_cnt;
`endif
    case (state)
      SCAN: begin
        // Rows are only trusted at the end of a dwell, after the column change has settled.
        if (dwell_cnt == DWELL_LAST) begin
          dwell_d = '0;
          if ($onehot(rs)) begin
            cand_row_d = rs;
            cand_col_d = col_drive_q;
            state_d    = DEBOUNCE;
          end else begin
            col_drive_d = col_rot;
          end
        end else begin
          dwell_d = dwell_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs != cand_row) begin
          state_d     = SCAN;
          col_drive_d = col_rot;
        end else if (deb_cnt == DEB_LAST) begin
          state_d     = HELD;
          row_out_d   = cand_row;
          col_out_d   = cand_col;
          key_code_d  = rc_to_code(cand_row, cand_col);
          key_valid_d = 1'b1;
        end else begin
          deb_d = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        // A bounce or a second key both break the run of all-zero rows.
        if (rs != '0) begin
          rel_d = '0;
        end else if (rel_cnt == DEB_LAST) begin
          state_d     = SCAN;
          col_drive_d = col_rot;
          row_out_d   = '0;
          col_out_d   = '0;
          key_code_d  = '0;
        end else begin
          rel_d = rel_cnt + 1'b1;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (state_d == HELD) begin
          if (rep_cnt == REP_LAST) begin
            rep_d       = '0;
            key_valid_d = 1'b1;
          end else begin
            rep_d = rep_cnt + 1'b1;
          end
        end
`endif
      end
      default: state_d = SCAN;
    endcase
    if (state_d != state) begin
      dwell_d = '0;
      deb_d   = '0;
      rel_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_d   = '0;
`endif
    end
  end

  assign kp.col_drive = col_drive_q;
  assign kp.row_out   = row_out_q;
  assign kp.col_out   = col_out_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
endmodule
